// File: rtl/e_muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide engine: the op codes
// that the HILO unit drives onto `op`, and the engine's state encoding.
package e_muldiv_iter_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/e_muldiv_iter.sv
// e_muldiv_iter: iterative WIDTH-bit multiply/divide engine for the E stage.
// It uses a radix-2 shift-add multiplier and a restoring divider. Both run on
// magnitudes. Signs are captured at launch and applied in a one-cycle fix step.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   start        launch request, honoured only in IDLE
//   op           MD_MULT / MD_MULTU / MD_DIV / MD_DIVU, sampled with start
//   a, b         rs / rt operands, sampled with start
//   cancel       abort an in-flight op; no done is produced
//   busy         high while an op is in flight
//   done         registered one-cycle pulse; hi/lo are valid in that cycle
//   hi, lo       product high/low or remainder/quotient; held until next done
//
// state   | meaning
// --------+---------------------------------------------------------------
// MD_IDLE | waiting for start; operands and sign flags latched on launch
// MD_RUN  | WIDTH iterations, counter WIDTH-1 down to 0
// MD_FIX  | sign correction, hi/lo committed at the end of this cycle
// MD_DONE | results committed; done is raised on the following edge
module e_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import e_muldiv_iter_pkg::*;

  localparam logic [WIDTH-1:0]   ONE  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2 = (2*WIDTH)'(1);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + ONE;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate2(input logic [2*WIDTH-1:0] x);
    return ~x + ONE2;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? negate(x) : x;
  endfunction

  md_state_t state, state_nxt;

  // acc_hi doubles as the remainder, acc_lo as the quotient, operand holds the
  // multiplicand or the divisor.
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] operand;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             neg_res;
  logic             neg_rem;
  logic             divz;

  logic             launch;
  logic             in_div;
  logic             sgn_op, sa, sb;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ok;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0] fix_quo, fix_rem;

  always_ff @(posedge clk) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start && !cancel) state_nxt = MD_RUN;
      MD_RUN:  if (cancel) state_nxt = MD_IDLE;
               else if (cnt == '0) state_nxt = MD_FIX;
      MD_FIX:  state_nxt = cancel ? MD_IDLE : MD_DONE;
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    launch    = (state == MD_IDLE) && start && !cancel;
    in_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
    sgn_op    = (op == MD_MULT) || (op == MD_DIV);
    sa        = sgn_op && a[WIDTH-1];
    sb        = sgn_op && b[WIDTH-1];
    mul_sum   = acc_hi + {1'b0, (acc_lo[0] ? operand : '0)};
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_ok    = div_shift >= {1'b0, operand};
    div_trial = div_shift - {1'b0, operand};
    fix_prod  = neg_res ? negate2({acc_hi[WIDTH-1:0], acc_lo}) : {acc_hi[WIDTH-1:0], acc_lo};
    // With a zero divisor the restoring loop already yields an all-ones
    // quotient and |a| as remainder; skipping the quotient negation and
    // restoring the sign of a leaves hi equal to the raw dividend.
    fix_quo   = (neg_res && !divz) ? negate(acc_lo) : acc_lo;
    fix_rem   = neg_rem ? negate(acc_hi[WIDTH-1:0]) : acc_hi[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      operand <= '0;
      cnt     <= '0;
      op_q    <= MD_MULT;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      divz    <= 1'b0;
    end else begin
      // busy covers RUN/FIX delayed by one edge so that it falls on the same
      // edge done rises; a cancel drops it on the cancelling edge itself.
      busy <= ((state == MD_RUN) || (state == MD_FIX)) && !cancel;
      done <= (state == MD_DONE);
      if (launch) begin
        op_q    <= op;
        acc_hi  <= '0;
        cnt     <= CNT_W'(WIDTH - 1);
        neg_res <= sa ^ sb;
        neg_rem <= sa;
        if ((op == MD_DIV) || (op == MD_DIVU)) begin
          acc_lo  <= mag(a, sa);
          operand <= mag(b, sb);
          divz    <= (b == '0);
        end else begin
          acc_lo  <= mag(b, sb);
          operand <= mag(a, sa);
          divz    <= 1'b0;
        end
      end else if (state == MD_RUN && !cancel) begin
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
        if (in_div) begin
          acc_hi <= div_ok ? div_trial : div_shift;
          acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
        end else begin
          acc_hi <= {1'b0, mul_sum[WIDTH:1]};
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
      end else if (state == MD_FIX && !cancel) begin
        if (in_div) begin
          hi <= fix_rem;
          lo <= fix_quo;
        end else begin
          hi <= fix_prod[2*WIDTH-1:WIDTH];
          lo <= fix_prod[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_e_muldiv_iter.sv
module tb_e_muldiv_iter;
  import e_muldiv_iter_pkg::*;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  e_muldiv_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic, SV division truncates toward zero
  // and the remainder follows the dividend's sign.
  task automatic ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MD_MULT:  p = 64'(sx * sy);
      MD_MULTU: p = {32'd0, x} * {32'd0, y};
      MD_DIV: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin q = sx / sy; r = sx % sy; p = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    eh = p[63:32];
    el = p[31:0];
  endtask

  // Launches one op and waits (bounded) for done. lat = -1 on timeout.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] h, output logic [31:0] l,
                       output int lat, output int busy_bad, output logic done_after);
    int n;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; lat = -1; busy_bad = 0; h = 'x; l = 'x; done_after = 1'b0;
    while (n < 60 && lat < 0) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        lat = n; h = hi; l = lo;
        if (busy !== 1'b0) busy_bad++;
      end else if (busy !== 1'b1) busy_bad++;
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [6] = '{MD_MULTU, MD_MULT, MD_DIV, MD_DIVU, MD_DIV, MD_DIVU};
    logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd10};
    logic [31:0] bs  [6] = '{32'hFFFF_FFFF, 32'd3, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] ehs [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd0, 32'd1};
    logic [31:0] els [6] = '{32'h0000_0001, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3};
    logic [31:0] h, l;
    int lat, bb;
    logic da;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], as[i], bs[i], h, l, lat, bb, da);
      n_tests++; if (lat != LAT) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT); end
      n_tests++; if (h !== ehs[i] || l !== els[i]) begin
        n_fail++; $display("FAIL dir%0d_result got %h/%h want %h/%h", i, h, l, ehs[i], els[i]); end
      n_tests++; if (bb != 0 || da !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_handshake busy_errs %0d done_after %b want 0/0", i, bb, da); end
    end
  endtask

  task automatic test_ignore_start();
    int n, dones, dlat, busy_late;
    logic [31:0] h, l;
    @(negedge clk);
    op = MD_DIVU; a = 32'd10; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; dones = 0; dlat = -1; busy_late = 0; h = 'x; l = 'x;
    while (n < 70) begin
      @(negedge clk);
      n++;
      if (n == 5) begin start = 1'b1; op = MD_MULTU; a = 32'h1234; b = 32'h99; end
      else if (n == 6) start = 1'b0;
      if (n == 33) begin start = 1'b1; op = MD_MULT; a = 32'd5; b = 32'd5; end
      else if (n == 34) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (dlat < 0) begin dlat = n; h = hi; l = lo; end
      end
      if (n > 35 && busy !== 1'b0) busy_late++;
    end
    n_tests++; if (dones != 1 || dlat != LAT) begin
      n_fail++; $display("FAIL ignore_start_dones got %0d at %0d want 1 at %0d", dones, dlat, LAT); end
    n_tests++; if (h !== 32'd1 || l !== 32'd3) begin
      n_fail++; $display("FAIL ignore_start_result got %h/%h want 1/3", h, l); end
    n_tests++; if (busy_late != 0) begin
      n_fail++; $display("FAIL start_in_done_accepted busy cycles %0d want 0", busy_late); end
  endtask

  task automatic test_cancel();
    logic [31:0] h, l, eh, el;
    int lat, bb, n, dones;
    logic da;
    do_op(MD_DIVU, 32'd47, 32'd6, h, l, lat, bb, da);
    n_tests++; if (h !== 32'd5 || l !== 32'd7) begin
      n_fail++; $display("FAIL cancel_setup got %h/%h want 5/7", h, l); end
    @(negedge clk);
    op = MD_MULT; a = 32'h0001_2345; b = 32'hFFFF_0003; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 10) begin @(negedge clk); n++; end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got %b want 0", busy); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL cancel_no_done got %0d want 0", dones); end
    n_tests++; if (hi !== 32'd5 || lo !== 32'd7) begin
      n_fail++; $display("FAIL cancel_hold got %h/%h want 5/7", hi, lo); end
    do_op(MD_MULT, 32'd3, 32'hFFFF_FFFC, h, l, lat, bb, da);
    ref_model(MD_MULT, 32'd3, 32'hFFFF_FFFC, eh, el);
    n_tests++; if (lat != LAT || h !== eh || l !== el) begin
      n_fail++; $display("FAIL cancel_recover got %h/%h lat %0d want %h/%h lat %0d", h, l, lat, eh, el, LAT); end
  endtask

  task automatic test_reset_mid();
    int n, dones, busys;
    @(negedge clk);
    op = MD_DIV; a = 32'hFFFF_FF9C; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 20) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_flags busy %b done %b want 0/0", busy, done); end
    n_tests++; if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL midreset_hilo got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    op = MD_MULTU; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    dones = 0; busys = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (busy !== 1'b0) busys++;
    end
    n_tests++; if (dones != 0 || busys != 0) begin
      n_fail++; $display("FAIL start_cancel_launched done %0d busy %0d want 0/0", dones, busys); end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y, h, l, eh, el;
    int lat, bb;
    logic da;
    for (int i = 0; i < 1500; i++) begin
      o = 2'($urandom_range(0, 3));
      x = pick_operand();
      y = pick_operand();
      ref_model(o, x, y, eh, el);
      do_op(o, x, y, h, l, lat, bb, da);
      n_tests++; if (h !== eh || l !== el) begin
        n_fail++; $display("FAIL rnd%0d_result op %0d a %h b %h got %h/%h want %h/%h", i, o, x, y, h, l, eh, el); end
      n_tests++; if (lat != LAT) begin
        n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, LAT); end
      n_tests++; if (bb != 0 || da !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_handshake busy_errs %0d done_after %b want 0/0", i, bb, da); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
